// File: rtl/memory_stage.sv
// memory_stage: pipeline MEM stage.
// Accepts execute results on ixmem, runs loads/stores against a single-port
// data memory (req/gnt/rvalid handshake) and emits one writeback record per
// accepted instruction on memwb. Stalls upstream while a memory transaction is
// outstanding; a transaction that exceeds TIMEOUT_CYCLES in REQ+WAIT is aborted
// with a one-cycle mem_err_p1 pulse and retired without a register write.
//
// Ports:
//   clk, rst                        clock, async active-high reset
//   ixmem_valid_p1 .. mem_data_in   execute-stage record (sampled in IDLE only)
//   stall_mem_p1                    upstream hold while a transaction is in flight
//   dmem_req/we/addr/wdata          memory request (driven during REQ only)
//   dmem_gnt/rvalid/rdata           memory grant and read response
//   wb_valid_memwb_p1, dest_*_memwb writeback record (1-cycle valid pulse)
//   mem_err_p1                      1-cycle pulse on timeout abort
module memory_stage #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ixmem_valid_p1,
    input  logic [15:0] dest_reg_value_ixmem_p1,
    input  logic [2:0]  dest_reg_index_ixmem_p1,
    input  logic        dest_reg_write_valid_ixmem_p1,
    input  logic [15:0] mem_addr_ixmem_p1,
    input  logic        ldst_valid_ixmem_p1,
    input  logic [1:0]  store_valid_ixmem_p1,
    input  logic [15:0] mem_data_in_ixmem_p1,
    output logic        stall_mem_p1,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [15:0] dmem_addr,
    output logic [15:0] dmem_wdata,
    input  logic        dmem_gnt,
    input  logic        dmem_rvalid,
    input  logic [15:0] dmem_rdata,
    output logic        wb_valid_memwb_p1,
    output logic [15:0] dest_reg_value_memwb_p1,
    output logic [2:0]  dest_reg_index_memwb_p1,
    output logic        dest_reg_write_valid_memwb_p1,
    output logic        mem_err_p1
);

    localparam int unsigned DW = 16;
    localparam int unsigned IW = 3;
    localparam int unsigned CW = 8;
    // Abort when the cycle being spent is the TIMEOUT_CYCLES-th one.
    localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2
    } state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [DW-1:0] op_addr_q, op_addr_d;
    logic [DW-1:0] op_wdata_q, op_wdata_d;
    logic [DW-1:0] op_value_q, op_value_d;
    logic [IW-1:0] op_index_q, op_index_d;
    logic          op_store_q, op_store_d;
    logic          op_upd_q, op_upd_d;
    logic          wb_valid_q, wb_valid_d;
    logic [DW-1:0] wb_value_q, wb_value_d;
    logic [IW-1:0] wb_index_q, wb_index_d;
    logic          wb_wv_q, wb_wv_d;
    logic          err_q, err_d;

    logic          timeout_c;
    logic [CW-1:0] cnt_inc_c;

    // State and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            op_addr_q  <= '0;
            op_wdata_q <= '0;
            op_value_q <= '0;
            op_index_q <= '0;
            op_store_q <= 1'b0;
            op_upd_q   <= 1'b0;
            wb_valid_q <= 1'b0;
            wb_value_q <= '0;
            wb_index_q <= '0;
            wb_wv_q    <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            op_addr_q  <= op_addr_d;
            op_wdata_q <= op_wdata_d;
            op_value_q <= op_value_d;
            op_index_q <= op_index_d;
            op_store_q <= op_store_d;
            op_upd_q   <= op_upd_d;
            wb_valid_q <= wb_valid_d;
            wb_value_q <= wb_value_d;
            wb_index_q <= wb_index_d;
            wb_wv_q    <= wb_wv_d;
            err_q      <= err_d;
        end
    end

    // >= rather than == so a grant landing on the last allowed cycle still
    // leaves the following WAIT cycle bounded.
    assign timeout_c = (cnt_q >= TO_LAST);
    // Saturating increment keeps the counter from wrapping back under the limit.
    assign cnt_inc_c = (cnt_q == {CW{1'b1}}) ? cnt_q : cnt_q + CW'(1);

    // Next-state and writeback record generation.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        op_addr_d  = op_addr_q;
        op_wdata_d = op_wdata_q;
        op_value_d = op_value_q;
        op_index_d = op_index_q;
        op_store_d = op_store_q;
        op_upd_d   = op_upd_q;
        wb_valid_d = 1'b0;
        wb_value_d = wb_value_q;
        wb_index_d = wb_index_q;
        wb_wv_d    = wb_wv_q;
        err_d      = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (ixmem_valid_p1) begin
                    if (ldst_valid_ixmem_p1) begin
                        op_addr_d  = mem_addr_ixmem_p1;
                        op_wdata_d = mem_data_in_ixmem_p1;
                        op_value_d = dest_reg_value_ixmem_p1;
                        op_index_d = dest_reg_index_ixmem_p1;
                        op_store_d = store_valid_ixmem_p1[0];
                        op_upd_d   = store_valid_ixmem_p1[1];
                        cnt_d      = '0;
                        state_d    = ST_REQ;
                    end else begin
                        wb_valid_d = 1'b1;
                        wb_value_d = dest_reg_value_ixmem_p1;
                        wb_index_d = dest_reg_index_ixmem_p1;
                        wb_wv_d    = dest_reg_write_valid_ixmem_p1;
                    end
                end
            end
            ST_REQ: begin
                cnt_d = cnt_inc_c;
                if (dmem_gnt) begin
                    if (op_store_q) begin
                        state_d    = ST_IDLE;
                        wb_valid_d = 1'b1;
                        wb_value_d = op_value_q;
                        wb_index_d = op_index_q;
                        wb_wv_d    = op_upd_q;
                    end else begin
                        state_d = ST_WAIT;
                    end
                end else if (timeout_c) begin
                    state_d    = ST_IDLE;
                    err_d      = 1'b1;
                    wb_valid_d = 1'b1;
                    wb_value_d = op_value_q;
                    wb_index_d = op_index_q;
                    wb_wv_d    = 1'b0;
                end
            end
            ST_WAIT: begin
                cnt_d = cnt_inc_c;
                if (dmem_rvalid) begin
                    state_d    = ST_IDLE;
                    wb_valid_d = 1'b1;
                    wb_value_d = dmem_rdata;
                    wb_index_d = op_index_q;
                    wb_wv_d    = 1'b1;
                end else if (timeout_c) begin
                    state_d    = ST_IDLE;
                    err_d      = 1'b1;
                    wb_valid_d = 1'b1;
                    wb_value_d = op_value_q;
                    wb_index_d = op_index_q;
                    wb_wv_d    = 1'b0;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Memory-side and stall outputs decode registered state only.
    assign stall_mem_p1 = (state_q != ST_IDLE);
    assign dmem_req     = (state_q == ST_REQ);
    assign dmem_we      = dmem_req & op_store_q;
    assign dmem_addr    = dmem_req ? op_addr_q : '0;
    assign dmem_wdata   = dmem_req ? op_wdata_q : '0;

    assign wb_valid_memwb_p1             = wb_valid_q;
    assign dest_reg_value_memwb_p1       = wb_value_q;
    assign dest_reg_index_memwb_p1       = wb_index_q;
    assign dest_reg_write_valid_memwb_p1 = wb_wv_q;
    assign mem_err_p1                    = err_q;

endmodule

// File: doc/memory_stage.md
# memory_stage

Pipeline MEM stage: accepts execute-stage results on the ixmem interface, performs loads and stores against a single-port data memory using a request/grant/response handshake, and presents one writeback record per instruction on the memwb interface. Stalls upstream while a memory transaction is outstanding and aborts hung transactions with an error pulse after a programmable timeout. Sits between `execute` and the writeback stage; it is the consumer end of the ixmem interface `execute` drives.

## Interface
Parameters:
- TIMEOUT_CYCLES, 255: max cycles in REQ+WAIT before abort; range 1..255; counter 8 bits.

Ports. One clock; reset is asynchronous and active-high (clk, rst).
- clk  in  1  clock
- rst  in  1  async active-high reset
- ixmem_valid_p1  in  1  instruction present on ixmem inputs
- dest_reg_value_ixmem_p1  in  16  ALU result, or next PC for JL/JAL
- dest_reg_index_ixmem_p1  in  3  destination register
- dest_reg_write_valid_ixmem_p1  in  1  instruction writes a register
- mem_addr_ixmem_p1  in  16  load/store address
- ldst_valid_ixmem_p1  in  1  load or store
- store_valid_ixmem_p1  in  2  [0]=store; [1]=store-with-update (also writes dest_reg_value)
- mem_data_in_ixmem_p1  in  16  store data
- stall_mem_p1  out  1  upstream holds ixmem inputs stable while high
- dmem_req  out  1  memory request
- dmem_we  out  1  1=write, 0=read
- dmem_addr  out  16  request address
- dmem_wdata  out  16  write data
- dmem_gnt  in  1  request accepted this cycle
- dmem_rvalid  in  1  read data valid
- dmem_rdata  in  16  read data
- wb_valid_memwb_p1  out  1  writeback record valid (1-cycle pulse)
- dest_reg_value_memwb_p1  out  16  writeback value
- dest_reg_index_memwb_p1  out  3  writeback register
- dest_reg_write_valid_memwb_p1  out  1  register write enable
- mem_err_p1  out  1  1-cycle pulse on timeout abort

## Operation
- States: IDLE, REQ, WAIT. Sampling of ixmem inputs occurs only in IDLE on a rising edge with ixmem_valid_p1=1.
- Non-memory op (ldst_valid=0): copied to memwb registers; wb_valid=1 next cycle; stays IDLE.
- Load (ldst_valid=1, store_valid[0]=0): latch addr/index; IDLE->REQ. REQ drives dmem_req=1, dmem_we=0, dmem_addr. On dmem_gnt -> WAIT (req drops). WAIT: on dmem_rvalid capture dmem_rdata as dest value, write_valid=1, wb_valid=1 next cycle, ->IDLE. dmem_rvalid outside WAIT ignored.
- Store (store_valid[0]=1): REQ drives req=1, we=1, addr, wdata. On gnt -> IDLE, wb_valid=1 next cycle; dest_reg_write_valid = store_valid[1], value = dest_reg_value_ixmem_p1 latched at accept.
- ldst_valid=1 with store_valid=2'b10 treated as load.
- stall_mem_p1 = (state != IDLE); registered state only, no combinational path from dmem inputs.
- dmem_addr/wdata/we hold latched values throughout REQ; zero outside REQ.
- Timeout: 8-bit counter clears on accept, increments each REQ/WAIT cycle; when count reaches TIMEOUT_CYCLES without completion -> IDLE, mem_err_p1=1 one cycle, wb_valid=1 with dest_reg_write_valid=0 (instruction retired, no write).
- Exactly one wb_valid pulse per accepted instruction.

## Timing
- Reset: state IDLE; all outputs 0 (stall, dmem_*, wb_*, dest_*_memwb, mem_err); counter 0. Reset mid-transaction drops dmem_req immediately (async) and discards the in-flight op; no writeback.
- Non-memory latency: accept edge N -> wb_valid in cycle N+1.
- Load best case: accept edge N; REQ cycle N+1 with gnt; WAIT cycle N+2 with rvalid; wb_valid cycle N+3; stall high N+1..N+2; next accept at edge ending N+3.
- Store best case: gnt in N+1 -> wb_valid N+2; stall high N+1 only.
- Grant delays extend REQ; response delays extend WAIT; stall high the whole time.
- gnt and timeout on the same cycle: gnt wins. rvalid and timeout on the same cycle: rvalid wins, no error.
- Back-to-back non-memory ops: one accepted per cycle, wb_valid continuous.

## Test plan
- Reset then ALU op: value 0x1234, idx 3, write_valid 1 -> next cycle wb_valid=1, value 0x1234, idx 3; stall never high.
- Load addr 0x0040, gnt cycle 1, rvalid cycle 2 with rdata 0xBEEF -> req=1 we=0 addr 0x0040 for one cycle; wb value 0xBEEF idx as sent, write_valid 1; stall high 2 cycles.
- Store addr 0x0010 data 0x00AA, store_valid 2'b11, value 0x0012, gnt after 3 cycles -> req held 4 cycles with we=1, wdata 0x00AA; wb writes 0x0012.
- TIMEOUT_CYCLES=4, load with no gnt -> req high 4 cycles, mem_err pulse, wb_valid with write_valid 0, state IDLE.
- rst asserted in WAIT -> req/stall/wb 0 same cycle; late rvalid after reset ignored; next ALU op completes normally.
- Spurious rvalid while IDLE and ALU stream of 5 ops -> 5 wb pulses with correct values, no corruption.
